fifo_sync: RTL

Single-clock, parametrised synchronous FIFO: the same-clock successor to the team's dual-clock FIFO, for buffering between blocks that share one clock domain. It adds an occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses and a selectable first-word-fall-through (FWFT) read mode. No pointer synchronisers or Gray coding are needed; all flags are exact and update on the same edge as the operation.

---
 rtl/fifo_sync_if.sv | 38 +++
 rtl/fifo_sync.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fifo_sync_if.sv
// fifo_sync_if
// Groups the data/handshake/status signals of fifo_sync into one bundle.
// The clock and reset are kept outside the bundle as plain module ports.
//   i_wr_data, i_wr_en   : write side, driven by the producer
//   i_rd_en              : read (pop) request, driven by the consumer
//   o_rd_data, o_rd_valid: read side, driven by the FIFO
//   o_full, o_empty, o_almost_full, o_almost_empty, o_level : occupancy status
//   o_overflow, o_underflow : one-cycle pulses for rejected requests
// The master modport is the user of the FIFO, the slave modport is the FIFO.
interface fifo_sync_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);
  logic [DATASIZE-1:0] i_wr_data;
  logic                i_wr_en;
  logic                i_rd_en;
  logic [DATASIZE-1:0] o_rd_data;
  logic                o_rd_valid;
  logic                o_full;
  logic                o_empty;
  logic                o_almost_full;
  logic                o_almost_empty;
  logic [ADDRSIZE:0]   o_level;
  logic                o_overflow;
  logic                o_underflow;

  modport master (
    output i_wr_data, i_wr_en, i_rd_en,
    input  o_rd_data, o_rd_valid, o_full, o_empty, o_almost_full,
           o_almost_empty, o_level, o_overflow, o_underflow
  );

  modport slave (
    input  i_wr_data, i_wr_en, i_rd_en,
    output o_rd_data, o_rd_valid, o_full, o_empty, o_almost_full,
           o_almost_empty, o_level, o_overflow, o_underflow
  );
endinterface

// File: rtl/fifo_sync.sv
// fifo_sync
// Single-clock synchronous FIFO with exact occupancy count, programmable
// almost-full/almost-empty thresholds, overflow/underflow error pulses and a
// selectable first-word-fall-through read mode.
// Ports:
//   i_clk : clock, all logic on the rising edge
//   i_rst : synchronous active-high reset, dominates all requests
//   bus   : fifo_sync_if slave modport carrying the write/read handshake,
//           read data and status flags
module fifo_sync #(
  parameter int DATASIZE  = 8,
  parameter int ADDRSIZE  = 4,
  parameter int MEM_DEPTH = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4
) (
  input logic        i_clk,
  input logic        i_rst,
  fifo_sync_if.slave bus
);

  localparam logic [ADDRSIZE:0]   DEPTH_L = (ADDRSIZE+1)'(MEM_DEPTH);
  localparam logic [ADDRSIZE:0]   AF_L    = (ADDRSIZE+1)'(AF_THRESH);
  localparam logic [ADDRSIZE:0]   AE_L    = (ADDRSIZE+1)'(AE_THRESH);
  localparam logic [ADDRSIZE:0]   LVL_ONE = (ADDRSIZE+1)'(1);
  localparam logic [ADDRSIZE-1:0] PTR_ONE = ADDRSIZE'(1);

  logic [DATASIZE-1:0] mem [MEM_DEPTH];

  logic [ADDRSIZE-1:0] wrAddr_q, wrAddr_d;
  logic [ADDRSIZE-1:0] rdAddr_q, rdAddr_d;
  logic [ADDRSIZE:0]   level_q, level_d;
  logic [DATASIZE-1:0] rdData_q, rdData_d;
  logic                rdValid_q, rdValid_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  logic                full, empty;
  logic                wrAccept, rdAccept;
  logic [DATASIZE-1:0] fwftData;

  // Every flag is a decode of the level register, so flags move on the same
  // edge as the level with no lag or pessimism.
  assign full  = (level_q == DEPTH_L);
  assign empty = (level_q == '0);

  // A full FIFO still accepts a read (the write is the one rejected), and an
  // empty FIFO still accepts a write; there is no bypass path in either case.
  assign wrAccept = bus.i_wr_en && !full;
  assign rdAccept = bus.i_rd_en && !empty;

  // Next-state computation for pointers, level, the registered read port and
  // the error pulses. Pointers wrap naturally at MEM_DEPTH = 2**ADDRSIZE.
  always_comb begin
    wrAddr_d    = wrAddr_q;
    rdAddr_d    = rdAddr_q;
    level_d     = level_q;
    rdData_d    = rdData_q;
    rdValid_d   = 1'b0;
    overflow_d  = bus.i_wr_en && full;
    underflow_d = bus.i_rd_en && empty;

    if (wrAccept) begin
      wrAddr_d = wrAddr_q + PTR_ONE;
    end
    if (rdAccept) begin
      rdAddr_d  = rdAddr_q + PTR_ONE;
      rdData_d  = mem[rdAddr_q];
      rdValid_d = 1'b1;
    end

    case ({wrAccept, rdAccept})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Control state register. Reset clears pointers and level, which throws
  // away anything stored, and suppresses any error pulse for requests that
  // arrive in the reset cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wrAddr_q    <= '0;
      rdAddr_q    <= '0;
      level_q     <= '0;
      rdData_q    <= '0;
      rdValid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrAddr_q    <= wrAddr_d;
      rdAddr_q    <= rdAddr_d;
      level_q     <= level_d;
      rdData_q    <= rdData_d;
      rdValid_q   <= rdValid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array has no reset; only accepted writes touch it, and never
  // while reset is held.
  always_ff @(posedge i_clk) begin
    if (!i_rst && wrAccept) begin
      mem[wrAddr_q] <= bus.i_wr_data;
    end
  end

  // In fall-through mode the head word is shown directly; it is forced to
  // zero while empty so the output is clean after reset even though the
  // array itself holds stale contents.
  assign fwftData = empty ? '0 : mem[rdAddr_q];

  assign bus.o_rd_data      = (FWFT != 0) ? fwftData : rdData_q;
  assign bus.o_rd_valid     = (FWFT != 0) ? !empty   : rdValid_q;
  assign bus.o_full         = full;
  assign bus.o_empty        = empty;
  assign bus.o_almost_full  = (level_q >= AF_L);
  assign bus.o_almost_empty = (level_q <= AE_L);
  assign bus.o_level        = level_q;
  assign bus.o_overflow     = overflow_q;
  assign bus.o_underflow    = underflow_q;

endmodule
